ad_ip_jesd204_tpl_axi_master: RTL and testbench

//  AXI4-Lite initiator bridging the internal up_* register bus onto an AXI-Lite master port.
//  It is the requester end of the TPL regmap: firmware-side sequencers (link bring-up, profile

---
 rtl/ad_ip_jesd204_tpl_axi_master.sv | 190 +++++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_axi_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_axi_master.sv
// AXI4-Lite initiator for the up_* register bus, one transaction in flight; optional TPL_AXI_MASTER_TIMEOUT_EN.
// Latency: AXI valids 1 cycle after accept, ack 1 cycle after B/R handshake; stalls on slave, drops requests while busy.
module ad_ip_jesd204_tpl_axi_master #(
    parameter int AXI_ADDRESS_WIDTH = 13,
    parameter int TIMEOUT_CYCLES    = 1023
) (
    input  logic                           up_clk,
    input  logic                           up_rstn,
    input  logic                           up_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0]   up_waddr,
    input  logic [31:0]                    up_wdata,
    output logic                           up_wack,
    input  logic                           up_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0]   up_raddr,
    output logic [31:0]                    up_rdata,
    output logic                           up_rack,
    output logic                           up_err,
    output logic                           up_busy,
    output logic                           up_drop,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [AXI_ADDRESS_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                     m_axi_awprot,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    output logic [31:0]                    m_axi_wdata,
    output logic [3:0]                     m_axi_wstrb,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    input  logic [1:0]                     m_axi_bresp,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    output logic [AXI_ADDRESS_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                     m_axi_arprot,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    input  logic [31:0]                    m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp
);

    localparam int UAW = AXI_ADDRESS_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        ACK     = 3'd5
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [UAW-1:0] waddr_q;
    logic [UAW-1:0] raddr_q;
    logic [31:0]    wdata_q;
    logic           is_wr;
    logic           rd_pend;
    logic           aw_done;
    logic           w_done;
    logic           resp_err;
    logic           accept;
    logic           aw_hs;
    logic           w_hs;
    logic           ack_to_rd;
    logic           tmo;
    logic           unused_resp_lsb;

    assign accept          = (state == IDLE) && (up_wreq || up_rreq);
    assign aw_hs           = m_axi_awvalid && m_axi_awready;
    assign w_hs            = m_axi_wvalid && m_axi_wready;
    assign ack_to_rd       = (state == ACK) && rd_pend;
    assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

`ifdef TPL_AXI_MASTER_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    // counter starts at 0 in the first in-flight cycle, so this lands the ack TIMEOUT_CYCLES after accept
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] tmo_cnt;
    logic          in_flight;

    assign in_flight = (state != IDLE) && (state != ACK);

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            tmo_cnt <= '0;
        end else if (accept || ack_to_rd) begin
            tmo_cnt <= '0;
        end else if (in_flight) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo = in_flight && (tmo_cnt == TMO_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (up_wreq) state_nxt = WR_AW_W;
                     else if (up_rreq) state_nxt = RD_AR;
            WR_AW_W: if (tmo) state_nxt = ACK;
                     else if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
            WR_B:    if (m_axi_bvalid || tmo) state_nxt = ACK;
            RD_AR:   if (tmo) state_nxt = ACK;
                     else if (m_axi_arready) state_nxt = RD_R;
            RD_R:    if (m_axi_rvalid || tmo) state_nxt = ACK;
            ACK:     state_nxt = rd_pend ? RD_AR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = (state == WR_AW_W) && !aw_done;
        m_axi_wvalid  = (state == WR_AW_W) && !w_done;
        m_axi_bready  = (state == WR_B);
        m_axi_arvalid = (state == RD_AR);
        m_axi_rready  = (state == RD_R);
        up_wack       = (state == ACK) && is_wr;
        up_rack       = (state == ACK) && !is_wr;
        up_err        = (state == ACK) && resp_err;
        up_busy       = (state != IDLE);
    end

    assign m_axi_awaddr = {waddr_q, 2'b00};
    assign m_axi_araddr = {raddr_q, 2'b00};
    assign m_axi_wdata  = wdata_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hf;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            is_wr    <= 1'b0;
            rd_pend  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            resp_err <= 1'b0;
            up_rdata <= '0;
            up_drop  <= 1'b0;
        end else begin
            up_drop <= (state != IDLE) && (up_wreq || up_rreq);
            if (accept) begin
                is_wr   <= up_wreq;
                rd_pend <= up_wreq && up_rreq;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (up_wreq) begin
                    waddr_q <= up_waddr;
                    wdata_q <= up_wdata;
                end
                if (up_rreq) begin
                    raddr_q <= up_raddr;
                end
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            // the queued read behind a write starts straight from ACK
            if (ack_to_rd) begin
                is_wr   <= 1'b0;
                rd_pend <= 1'b0;
            end
            if (tmo) begin
                resp_err <= 1'b1;
                if (!is_wr) up_rdata <= '0;
            end else if ((state == WR_B) && m_axi_bvalid) begin
                resp_err <= m_axi_bresp[1];
            end else if ((state == RD_R) && m_axi_rvalid) begin
                resp_err <= m_axi_rresp[1];
                up_rdata <= m_axi_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_axi_master.sv
`timescale 1ns/1ps
module tb_ad_ip_jesd204_tpl_axi_master;
    localparam int AW  = 13;
    localparam int UAW = AW - 2;

    logic up_clk = 1'b0;
    logic up_rstn = 1'b0;
    logic up_wreq = 1'b0, up_rreq = 1'b0;
    logic [UAW-1:0] up_waddr = '0, up_raddr = '0;
    logic [31:0] up_wdata = '0, up_rdata;
    logic up_wack, up_rack, up_err, up_busy, up_drop;
    logic m_axi_awvalid, m_axi_awready = 1'b0;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0] m_axi_awprot, m_axi_arprot;
    logic m_axi_wvalid, m_axi_wready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0] m_axi_wstrb;
    logic m_axi_bvalid = 1'b0, m_axi_bready;
    logic [1:0] m_axi_bresp = 2'b00;
    logic m_axi_arvalid, m_axi_arready = 1'b0;
    logic m_axi_rvalid = 1'b0, m_axi_rready;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0] m_axi_rresp = 2'b00;

    always #5 up_clk = ~up_clk;

    ad_ip_jesd204_tpl_axi_master #(.AXI_ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .up_err(up_err), .up_busy(up_busy), .up_drop(up_drop),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awprot(m_axi_awprot), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp)
    );

    typedef struct packed {
        logic        is_wr;
        logic        err;
        logic [31:0] data;
        logic        tmo;
    } ack_t;

    logic [AW-1:0] exp_aw[$];
    logic [AW-1:0] exp_ar[$];
    logic [31:0]   exp_w[$];
    ack_t          exp_ack[$];

    int total = 0, bad = 0;
    int cyc = 0, req_cyc = 0;
    int n_aw = 0, n_w = 0, n_ar = 0, n_wack = 0, n_rack = 0, n_drop = 0;
    int last_resp_cyc = -10, last_wack_cyc = -10, last_rack_cyc = -10, ar_rise_cyc = -10;
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;

    // slave behaviour knobs, set by the directed tests
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic b_never = 1'b0, r_never = 1'b0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic hs_aw = 0, hs_w = 0, hs_ar = 0, hs_b = 0, hs_r = 0;
    logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_arv = 0, prev_arr = 0;
    logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
    logic [31:0] prev_wdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge up_clk);
        cyc++;
    end

    // slave responder and output monitor, both evaluated away from the active edge
    initial forever begin
        @(negedge up_clk);
        if (!up_rstn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
            prev_awv = 0; prev_wv = 0; prev_arv = 0;
        end else begin
            if (hs_aw) aw_got = 1;
            if (hs_w) w_got = 1;
            if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
            if (hs_b) b_pend = 0;
            if (hs_ar) begin r_pend = 1; r_cnt = 0; end
            if (hs_r) r_pend = 0;

            m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
            m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
            m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
            m_axi_bvalid  = b_pend && !b_never && (b_cnt >= b_dly);
            m_axi_bresp   = m_axi_bvalid ? bresp_cfg : 2'b00;
            m_axi_rvalid  = r_pend && !r_never && (r_cnt >= r_dly);
            m_axi_rdata   = m_axi_rvalid ? rdata_cfg : 32'hDEAD_BEEF;
            m_axi_rresp   = m_axi_rvalid ? rresp_cfg : 2'b00;

            hs_aw = m_axi_awvalid && m_axi_awready;
            hs_w  = m_axi_wvalid && m_axi_wready;
            hs_ar = m_axi_arvalid && m_axi_arready;
            hs_b  = m_axi_bvalid && m_axi_bready;
            hs_r  = m_axi_rvalid && m_axi_rready;
            aw_cnt = (m_axi_awvalid && !hs_aw) ? aw_cnt + 1 : 0;
            w_cnt  = (m_axi_wvalid && !hs_w) ? w_cnt + 1 : 0;
            ar_cnt = (m_axi_arvalid && !hs_ar) ? ar_cnt + 1 : 0;
            if (b_pend && !hs_b) b_cnt++;
            if (r_pend && !hs_r) r_cnt++;

            if (prev_awv && !prev_awr) begin
                chk("aw_hold", m_axi_awvalid, 1);
                chk("aw_addr_hold", m_axi_awaddr, prev_awaddr);
            end
            if (prev_wv && !prev_wr) begin
                chk("w_hold", m_axi_wvalid, 1);
                chk("w_data_hold", m_axi_wdata, prev_wdata);
            end
            if (prev_arv && !prev_arr) begin
                chk("ar_hold", m_axi_arvalid, 1);
                chk("ar_addr_hold", m_axi_araddr, prev_araddr);
            end
            if (m_axi_arvalid && !prev_arv) ar_rise_cyc = cyc;

            if (hs_aw) begin
                n_aw++;
                last_awaddr = m_axi_awaddr;
                chk("aw_expected", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0) chk("awaddr", m_axi_awaddr, exp_aw.pop_front());
                chk("awprot", m_axi_awprot, 0);
            end
            if (hs_w) begin
                n_w++;
                chk("w_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) chk("wdata", m_axi_wdata, exp_w.pop_front());
                chk("wstrb", m_axi_wstrb, 4'hf);
            end
            if (hs_ar) begin
                n_ar++;
                last_araddr = m_axi_araddr;
                chk("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) chk("araddr", m_axi_araddr, exp_ar.pop_front());
                chk("arprot", m_axi_arprot, 0);
            end
            if (hs_b || hs_r) last_resp_cyc = cyc;

            if (up_wack || up_rack) begin
                ack_t e;
                chk("ack_onehot", up_wack && up_rack, 0);
                chk("ack_busy", up_busy, 1);
                chk("ack_expected", exp_ack.size() != 0, 1);
                if (exp_ack.size() != 0) begin
                    e = exp_ack.pop_front();
                    chk("ack_kind", up_wack, e.is_wr);
                    chk("ack_err", up_err, e.err);
                    if (!e.is_wr) chk("ack_rdata", up_rdata, e.data);
                    if (!e.tmo) chk("ack_latency", cyc, last_resp_cyc + 1);
                end
                if (up_wack) begin n_wack++; last_wack_cyc = cyc; end
                if (up_rack) begin n_rack++; last_rack_cyc = cyc; end
            end else begin
                chk("err_quiet", up_err, 0);
            end
            if (up_drop) n_drop++;

            prev_awv = m_axi_awvalid; prev_awr = m_axi_awready; prev_awaddr = m_axi_awaddr;
            prev_wv = m_axi_wvalid; prev_wr = m_axi_wready; prev_wdata = m_axi_wdata;
            prev_arv = m_axi_arvalid; prev_arr = m_axi_arready; prev_araddr = m_axi_araddr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge up_clk);
        #1;
    endtask

    task automatic issue(input logic do_wr, input logic [UAW-1:0] wa, input logic [31:0] wd,
                         input logic do_rd, input logic [UAW-1:0] ra);
        up_wreq = do_wr; up_waddr = wa; up_wdata = wd;
        up_rreq = do_rd; up_raddr = ra;
        req_cyc = cyc;
        tick(1);
        up_wreq = 0; up_rreq = 0;
    endtask

    task automatic exp_write(input logic [UAW-1:0] a, input logic [31:0] d, input logic err);
        exp_aw.push_back({a, 2'b00});
        exp_w.push_back(d);
        exp_ack.push_back('{is_wr: 1'b1, err: err, data: 32'h0, tmo: 1'b0});
    endtask

    task automatic exp_read(input logic [UAW-1:0] a, input logic [31:0] d, input logic err);
        exp_ar.push_back({a, 2'b00});
        exp_ack.push_back('{is_wr: 1'b0, err: err, data: d, tmo: 1'b0});
    endtask

    task automatic wait_acks(input int nw, input int nr, input string nm);
        int k = 0;
        while ((n_wack < nw || n_rack < nr) && k < 300) begin
            tick(1);
            k++;
        end
        chk({nm, "_ack_in_time"}, k < 300, 1);
    endtask

    task automatic run_wr(input logic [UAW-1:0] a, input logic [31:0] d, input int awd, input int wd,
                          input logic [1:0] br);
        aw_dly = awd; w_dly = wd; b_dly = 1; bresp_cfg = br;
        exp_write(a, d, br[1]);
        issue(1, a, d, 0, '0);
        wait_acks(n_wack + 1, n_rack, "run_wr");
    endtask

    task automatic run_rd(input logic [UAW-1:0] a, input logic [31:0] d, input logic [1:0] rr);
        ar_dly = 1; r_dly = 1; rdata_cfg = d; rresp_cfg = rr;
        exp_read(a, d, rr[1]);
        issue(0, '0, '0, 1, a);
        wait_acks(n_wack, n_rack + 1, "run_rd");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_aw, b_w, b_ar, b_wk, b_rk, b_dr;

        // reset values
        tick(3);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_acks", {up_wack, up_rack, up_err, up_drop, up_busy}, 0);
        chk("rst_rdata", up_rdata, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        up_rstn = 1;
        tick(2);

        // write 0x010, awready 3 cycles late
        b_aw = n_aw; b_w = n_w;
        aw_dly = 3; w_dly = 0; b_dly = 2; bresp_cfg = 2'b00;
        exp_write(11'h010, 32'hA5A5_0001, 1'b0);
        issue(1, 11'h010, 32'hA5A5_0001, 0, '0);
        chk("t1_busy", up_busy, 1);
        chk("t1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        tick(1);
        chk("t1_w_dropped", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
        wait_acks(n_wack + 1, n_rack, "t1");
        chk("t1_one_aw", n_aw - b_aw, 1);
        chk("t1_one_w", n_w - b_w, 1);
        chk("t1_awaddr", last_awaddr, 13'h040);
        chk("t1_idle", up_busy, 0);

        // read 0x020 with SLVERR
        ar_dly = 1; r_dly = 2; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b10;
        exp_read(11'h020, 32'h1234_5678, 1'b1);
        issue(0, '0, '0, 1, 11'h020);
        wait_acks(n_wack, n_rack + 1, "t2");
        chk("t2_araddr", last_araddr, 13'h080);
        tick(5);
        chk("t2_rdata_held", up_rdata, 32'h1234_5678);

        // simultaneous write + read: write first, read chained with no idle cycle
        b_wk = n_wack; b_rk = n_rack; b_ar = n_ar;
        aw_dly = 0; w_dly = 0; b_dly = 1; bresp_cfg = 2'b00;
        ar_dly = 0; r_dly = 1; rdata_cfg = 32'hCAFE_0002; rresp_cfg = 2'b00;
        exp_write(11'h001, 32'h1111_1111, 1'b0);
        exp_read(11'h002, 32'hCAFE_0002, 1'b0);
        issue(1, 11'h001, 32'h1111_1111, 1, 11'h002);
        for (int k = 0; k < 100 && n_rack == b_rk; k++) begin
            chk("t3_busy_chain", up_busy, 1);
            tick(1);
        end
        chk("t3_one_wack", n_wack - b_wk, 1);
        chk("t3_one_rack", n_rack - b_rk, 1);
        chk("t3_one_ar", n_ar - b_ar, 1);
        chk("t3_order", last_wack_cyc < last_rack_cyc, 1);
        chk("t3_ar_after_wack", ar_rise_cyc, last_wack_cyc + 1);
        chk("t3_araddr", last_araddr, 13'h008);
        chk("t3_rdata", up_rdata, 32'hCAFE_0002);

        // read request while a write is busy is dropped
        b_ar = n_ar; b_rk = n_rack; b_dr = n_drop;
        b_dly = 6;
        exp_write(11'h003, 32'hDEAD_0003, 1'b0);
        issue(1, 11'h003, 32'hDEAD_0003, 0, '0);
        tick(1);
        issue(0, '0, '0, 1, 11'h055);
        chk("t4_drop_pulse", up_drop, 1);
        tick(1);
        chk("t4_drop_clear", up_drop, 0);
        wait_acks(n_wack + 1, n_rack, "t4");
        tick(5);
        chk("t4_no_ar", n_ar - b_ar, 0);
        chk("t4_no_rack", n_rack - b_rk, 0);
        chk("t4_drop_count", n_drop - b_dr, 1);

        // response code and address boundaries
        run_wr(11'h7FF, 32'h0000_0000, 0, 2, 2'b11);
        chk("t5_max_awaddr", last_awaddr, 13'h1FFC);
        run_wr(11'h000, 32'hFFFF_FFFF, 2, 2, 2'b01);
        chk("t5_min_awaddr", last_awaddr, 13'h0000);
        run_rd(11'h7FF, 32'hFFFF_FFFF, 2'b01);
        chk("t5_max_araddr", last_araddr, 13'h1FFC);

        // reset while awvalid is high aborts without an ack
        b_wk = n_wack; b_aw = n_aw;
        aw_dly = 20; w_dly = 20;
        issue(1, 11'h044, 32'h0BAD_0BAD, 0, '0);
        tick(1);
        chk("t6_awvalid_before", m_axi_awvalid, 1);
        #2 up_rstn = 0;
        #1;
        chk("t6_awvalid_async", m_axi_awvalid, 0);
        chk("t6_busy_async", up_busy, 0);
        tick(3);
        up_rstn = 1;
        tick(2);
        chk("t6_no_ack", n_wack - b_wk, 0);
        chk("t6_no_aw", n_aw - b_aw, 0);
        run_wr(11'h044, 32'h5555_AAAA, 0, 0, 2'b00);
        chk("t6_recover_awaddr", last_awaddr, 13'h110);
        chk("t6_recover_ack", n_wack - b_wk, 1);

`ifdef TPL_AXI_MASTER_TIMEOUT_EN
        // missing B response times out
        aw_dly = 0; w_dly = 0; b_never = 1;
        exp_aw.push_back({11'h00A, 2'b00});
        exp_w.push_back(32'h7777_0007);
        exp_ack.push_back('{is_wr: 1'b1, err: 1'b1, data: 32'h0, tmo: 1'b1});
        issue(1, 11'h00A, 32'h7777_0007, 0, '0);
        b_ar = req_cyc;
        wait_acks(n_wack + 1, n_rack, "t7w");
        chk("t7_wack_cycle", last_wack_cyc, b_ar + 16);
        chk("t7_bready_low", m_axi_bready, 0);
        b_never = 0; b_pend = 0;
        // missing R response times out and clears the returned data
        r_never = 1; ar_dly = 0;
        exp_ar.push_back({11'h00B, 2'b00});
        exp_ack.push_back('{is_wr: 1'b0, err: 1'b1, data: 32'h0, tmo: 1'b1});
        issue(0, '0, '0, 1, 11'h00B);
        b_ar = req_cyc;
        wait_acks(n_wack, n_rack + 1, "t7r");
        chk("t7_rack_cycle", last_rack_cyc, b_ar + 16);
        chk("t7_rdata_zero", up_rdata, 0);
        r_never = 0; r_pend = 0;
        tick(2);
`endif

        tick(3);
        chk("end_aw_drained", exp_aw.size(), 0);
        chk("end_w_drained", exp_w.size(), 0);
        chk("end_ar_drained", exp_ar.size(), 0);
        chk("end_ack_drained", exp_ack.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
